// File: rtl/instr_fetch_ctrl_if.sv
// rtl/instr_fetch_ctrl_if.sv - memory, redirect and decode handshake signals of the fetch sequencer
interface instr_fetch_ctrl_if;
    logic        MemRdEn;
    logic [15:0] MemAddr;
    logic [7:0]  MemRdData;
    logic        BranchTaken;
    logic [15:0] BranchTarget;
    logic        InstrValid;
    logic        InstrReady;
    logic [15:0] Instruction;
    logic [15:0] InstrPC;
    logic        Fault;
    logic [15:0] FaultPC;

    modport master (
        output MemRdEn, MemAddr, InstrValid, Instruction, InstrPC, Fault, FaultPC,
        input  MemRdData, BranchTaken, BranchTarget, InstrReady
    );

    modport slave (
        input  MemRdEn, MemAddr, InstrValid, Instruction, InstrPC, Fault, FaultPC,
        output MemRdData, BranchTaken, BranchTarget, InstrReady
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - byte-wide instruction fetch sequencer with prefetch FIFO; ALIGN_CHECK_EN faults odd branch targets
module instr_fetch_ctrl #(
    parameter int          MEM_BYTES  = 128,
    parameter logic [15:0] RESET_PC   = 16'd0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    instr_fetch_ctrl_if.master bus
);
    localparam logic [2:0]  DEPTH3   = 3'(FIFO_DEPTH);
    localparam logic [1:0]  LAST_PTR = 2'(FIFO_DEPTH - 1);
    localparam logic [16:0] MEM_LIM  = 17'(MEM_BYTES);

    typedef enum logic [2:0] {S_HI, S_LO, S_CAP, S_WAIT, S_FAULT} state_t;

    state_t      state, state_n;
    logic [15:0] fetch_pc, fetch_pc_n;
    logic        req_en_n, req_lo, req_lo_n;
    logic [15:0] req_addr_n;
    logic        rsp_valid, rsp_lo;
    logic [15:0] rsp_addr;
    logic [7:0]  hi_byte;
    logic [15:0] hi_pc;
    logic [31:0] fifo_mem [0:3];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count, resv, resv_n;
    logic        fault_n;
    logic [15:0] fault_pc_n;
    logic        instr_valid, pop, push, flush, issue, decide;
    logic [15:0] dec_pc;

    // resv counts FIFO entries plus instructions already requested, so a push always finds room
    assign instr_valid     = (count != 3'd0);
    assign pop             = instr_valid && bus.InstrReady;
    assign push            = rsp_valid && rsp_lo && !flush;
    assign bus.InstrValid  = instr_valid;
    assign bus.Instruction = instr_valid ? fifo_mem[rd_ptr][15:0]  : 16'd0;
    assign bus.InstrPC     = instr_valid ? fifo_mem[rd_ptr][31:16] : 16'd0;
    assign resv_n          = flush ? {2'b00, issue} : resv + {2'b00, issue} - {2'b00, pop};

    // next state, next request and fault update; a redirect makes the fetch decision for its target at once
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_en_n   = 1'b0;
        req_addr_n = 16'd0;
        req_lo_n   = 1'b0;
        issue      = 1'b0;
        flush      = 1'b0;
        fault_n    = bus.Fault;
        fault_pc_n = bus.FaultPC;
        decide     = 1'b0;
        dec_pc     = fetch_pc;
        case (state)
            S_HI, S_WAIT: decide = 1'b1;
            S_LO: begin
                req_en_n   = 1'b1;
                req_addr_n = fetch_pc + 16'd1;
                req_lo_n   = 1'b1;
                state_n    = S_CAP;
            end
            S_CAP: begin
                fetch_pc_n = fetch_pc + 16'd2;
                dec_pc     = fetch_pc + 16'd2;
                decide     = 1'b1;
            end
            default: ;
        endcase
        if (bus.BranchTaken) begin
            flush      = 1'b1;
            fault_n    = 1'b0;
            req_en_n   = 1'b0;
            req_addr_n = 16'd0;
            req_lo_n   = 1'b0;
            state_n    = S_HI;
            fetch_pc_n = bus.BranchTarget;
            dec_pc     = bus.BranchTarget;
            decide     = 1'b1;
`ifdef ALIGN_CHECK_EN
            if (bus.BranchTarget[0]) begin
                decide     = 1'b0;
                fault_n    = 1'b1;
                fault_pc_n = bus.BranchTarget;
                state_n    = S_FAULT;
            end
`else
`endif
        end
        if (decide) begin
            if (({1'b0, dec_pc} + 17'd1) >= MEM_LIM) begin
                fault_n    = 1'b1;
                fault_pc_n = dec_pc;
                state_n    = S_FAULT;
            end else if (flush || (resv < DEPTH3) || pop) begin
                issue      = 1'b1;
                req_en_n   = 1'b1;
                req_addr_n = dec_pc;
                state_n    = S_LO;
            end else begin
                state_n    = S_WAIT;
            end
        end
    end

    // state, registered memory request, response tracking and fault registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_HI;
            fetch_pc    <= RESET_PC;
            bus.MemRdEn <= 1'b0;
            bus.MemAddr <= 16'd0;
            req_lo      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_lo      <= 1'b0;
            rsp_addr    <= 16'd0;
            resv        <= 3'd0;
            bus.Fault   <= 1'b0;
            bus.FaultPC <= 16'd0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            bus.MemRdEn <= req_en_n;
            bus.MemAddr <= req_addr_n;
            req_lo      <= req_lo_n;
            rsp_valid   <= bus.MemRdEn && !flush;
            rsp_lo      <= req_lo;
            rsp_addr    <= bus.MemAddr;
            resv        <= resv_n;
            bus.Fault   <= fault_n;
            bus.FaultPC <= fault_pc_n;
        end
    end

    // high-byte capture and FIFO pointers; a redirect empties the FIFO after its same-cycle pop
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hi_byte <= 8'd0;
            hi_pc   <= 16'd0;
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count   <= 3'd0;
        end else begin
            if (rsp_valid && !rsp_lo) begin
                hi_byte <= bus.MemRdData;
                hi_pc   <= rsp_addr;
            end
            if (flush) begin
                wr_ptr <= 2'd0;
                rd_ptr <= 2'd0;
                count  <= 3'd0;
            end else begin
                if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? 2'd0 : wr_ptr + 2'd1;
                if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? 2'd0 : rd_ptr + 2'd1;
                count <= count + {2'b00, push} - {2'b00, pop};
            end
        end
    end

    // FIFO storage: {PC, hi byte, lo byte}
    always_ff @(posedge Clock) begin
        if (push) fifo_mem[wr_ptr] <= {hi_pc, hi_byte, bus.MemRdData};
    end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - table-driven bench for instr_fetch_ctrl
module tb_instr_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    instr_fetch_ctrl_if bus();
    logic [7:0] mem [0:255];
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic rst, rdy, br;
        logic [15:0] tgt;
        logic e_en;
        logic [15:0] e_addr;
        logic e_val;
        logic [15:0] e_ins, e_ipc;
        logic e_flt;
        logic [15:0] e_fpc;
    } vec_t;

    vec_t tbl[$];

    instr_fetch_ctrl #(.MEM_BYTES(128), .RESET_PC(16'd0), .FIFO_DEPTH(2)) dut (
        .Clock(clk),
        .Reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // byte memory: data for the request seen at an edge is presented for the following cycle
    always @(posedge clk) bus.MemRdData <= mem[bus.MemAddr[7:0]];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic r, input logic rdy, input logic br, input logic [15:0] tgt,
                                input logic en, input logic [15:0] addr, input logic val,
                                input logic [15:0] ins, input logic [15:0] ipc,
                                input logic flt, input logic [15:0] fpc);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.br = br; v.tgt = tgt;
        v.e_en = en; v.e_addr = addr; v.e_val = val; v.e_ins = ins; v.e_ipc = ipc;
        v.e_flt = flt; v.e_fpc = fpc;
        return v;
    endfunction

    initial begin
        int n;
        logic [15:0] first_addr;
        for (int a = 0; a < 256; a++) mem[a] = 8'hEE;
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
        mem[4] = 8'h9A; mem[5] = 8'hBC; mem[6] = 8'hDE; mem[7] = 8'hF0;
        mem[8'h40] = 8'hA5; mem[8'h41] = 8'h5A;
        mem[8'h7E] = 8'hC3; mem[8'h7F] = 8'h3C;

        // steady stream with decode always ready
        tbl.push_back(mk(0,1,0,0, 0,16'h0000, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0000, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0001, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0002, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0003, 1,16'h1234,16'h0000, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0004, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0005, 1,16'h5678,16'h0002, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0006, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0007, 1,16'h9ABC,16'h0004, 0,0));
        tbl.push_back(mk(1,0,0,0, 1,16'h0008, 0,0,0, 0,0));
        // decode stalled: FIFO fills, requests stop, then drains in order
        tbl.push_back(mk(0,0,0,0, 0,16'h0000, 0,0,0, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,16'h0000, 0,0,0, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,16'h0001, 0,0,0, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,16'h0002, 0,0,0, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,16'h0003, 1,16'h1234,16'h0000, 0,0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0,0,0,0, 0,16'h0000, 1,16'h1234,16'h0000, 0,0));
        tbl.push_back(mk(0,1,0,0, 0,16'h0000, 1,16'h1234,16'h0000, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0004, 1,16'h5678,16'h0002, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0005, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0006, 0,0,0, 0,0));
        // redirect to 0x40 while the low-byte request is outstanding
        tbl.push_back(mk(0,1,1,16'h0040, 1,16'h0007, 1,16'h9ABC,16'h0004, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0040, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0041, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0042, 0,0,0, 0,0));
        // last legal instruction at 0x7E, then range fault at 0x80
        tbl.push_back(mk(0,1,1,16'h007E, 1,16'h0043, 1,16'hA55A,16'h0040, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h007E, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h007F, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 0,16'h0000, 0,0,0, 1,16'h0080));
        tbl.push_back(mk(0,1,0,0, 0,16'h0000, 1,16'hC33C,16'h007E, 1,16'h0080));
        tbl.push_back(mk(0,1,0,0, 0,16'h0000, 0,0,0, 1,16'h0080));
        tbl.push_back(mk(0,1,1,16'h0000, 0,16'h0000, 0,0,0, 1,16'h0080));
        tbl.push_back(mk(0,1,0,0, 1,16'h0000, 0,0,0, 0,0));
        // target whose second byte is out of range faults without a request
        tbl.push_back(mk(0,1,1,16'h007F, 1,16'h0001, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 0,16'h0000, 0,0,0, 1,16'h007F));
        tbl.push_back(mk(0,1,1,16'h0003, 0,16'h0000, 0,0,0, 1,16'h007F));
`ifdef ALIGN_CHECK_EN
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0,1,0,0, 0,16'h0000, 0,0,0, 1,16'h0003));
`else
        tbl.push_back(mk(0,1,0,0, 1,16'h0003, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0004, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0005, 0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,16'h0006, 1,16'h789A,16'h0003, 0,0));
`endif

        bus.InstrReady = 1'b0;
        bus.BranchTaken = 1'b0;
        bus.BranchTarget = 16'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_addr", bus.MemAddr, 16'h0000);
        chk("reset_instr", bus.Instruction, 16'h0000);
        chk("reset_pc", bus.InstrPC, 16'h0000);
        chk("reset_faultpc", bus.FaultPC, 16'h0000);

        for (int i = 0; i < tbl.size(); i++) begin
            chk($sformatf("row%0d_en", i), bus.MemRdEn, tbl[i].e_en);
            if (tbl[i].e_en) chk($sformatf("row%0d_addr", i), bus.MemAddr, tbl[i].e_addr);
            chk($sformatf("row%0d_valid", i), bus.InstrValid, tbl[i].e_val);
            if (tbl[i].e_val) begin
                chk($sformatf("row%0d_instr", i), bus.Instruction, tbl[i].e_ins);
                chk($sformatf("row%0d_ipc", i), bus.InstrPC, tbl[i].e_ipc);
            end
            chk($sformatf("row%0d_fault", i), bus.Fault, tbl[i].e_flt);
            if (tbl[i].e_flt) chk($sformatf("row%0d_faultpc", i), bus.FaultPC, tbl[i].e_fpc);
            rst = tbl[i].rst;
            bus.InstrReady = tbl[i].rdy;
            bus.BranchTaken = tbl[i].br;
            bus.BranchTarget = tbl[i].tgt;
            @(negedge clk);
        end

        // back-to-back redirects: the second target wins
        bus.InstrReady = 1'b1;
        bus.BranchTaken = 1'b1;
        bus.BranchTarget = 16'h0040;
        @(negedge clk);
        bus.BranchTarget = 16'h0004;
        @(negedge clk);
        bus.BranchTaken = 1'b0;
        n = 0;
        while (!bus.InstrValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_latency", n, 3);
        chk("b2b_pc", bus.InstrPC, 16'h0004);
        chk("b2b_instr", bus.Instruction, 16'h9ABC);
        chk("b2b_fault", bus.Fault, 1'b0);

        // reset while two entries are buffered
        bus.InstrReady = 1'b0;
        bus.BranchTaken = 1'b1;
        bus.BranchTarget = 16'h0000;
        @(negedge clk);
        bus.BranchTaken = 1'b0;
        repeat (7) @(negedge clk);
        chk("full_valid", bus.InstrValid, 1'b1);
        chk("full_instr", bus.Instruction, 16'h1234);
        chk("full_en", bus.MemRdEn, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", bus.InstrValid, 1'b0);
        chk("mid_rst_fault", bus.Fault, 1'b0);
        chk("mid_rst_en", bus.MemRdEn, 1'b0);
        rst = 1'b0;
        n = 0;
        first_addr = 16'hFFFF;
        while (!bus.InstrValid && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.MemRdEn && first_addr == 16'hFFFF) first_addr = bus.MemAddr;
        end
        chk("restart_latency", n, 4);
        chk("restart_addr", first_addr, 16'h0000);
        chk("restart_instr", bus.Instruction, 16'h1234);
        chk("restart_pc", bus.InstrPC, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer in front of the byte-wide instruction memory (big-endian: high byte at PC, low byte at PC+1). Owns the fetch PC, issues two byte reads per instruction and assembles 16-bit instructions into a small prefetch FIFO. Delivers instructions to decode over a valid/ready handshake, with branch redirect/flush and an out-of-range fault.

Parameters:
MEM_BYTES, 128, instruction memory size in bytes; a fetch is legal only if FetchPC+1 < MEM_BYTES
RESET_PC, 16'd0, fetch PC loaded on reset
FIFO_DEPTH, 2, prefetch entries (each entry is {PC[15:0], Instruction[15:0]}); legal values 1..4

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
MemRdEn  output  1  byte read request this cycle (registered)
MemAddr  output  16  byte address of request (registered)
MemRdData  input  8  read data, valid the cycle after the request
BranchTaken  input  1  one-cycle redirect pulse
BranchTarget  input  16  new fetch PC, sampled when BranchTaken=1
InstrValid  output  1  FIFO head valid
InstrReady  input  1  decode accepts head
Instruction  output  16  FIFO head instruction ({hi,lo})
InstrPC  output  16  address of FIFO head instruction
Fault  output  1  sticky fetch fault
FaultPC  output  16  PC that caused the fault

Behaviour:
- Reset (overrides everything): FetchPC=RESET_PC, FIFO empty, state=HI, MemRdEn=0, MemAddr=0, InstrValid=0, Instruction=0, InstrPC=0, Fault=0, FaultPC=0. In-flight bytes are discarded.
- Memory timing: request in cycle t (MemRdEn=1, MemAddr=A) -> MemRdData=mem[A], sampled at end of cycle t+1.
- States: HI, LO, CAP, WAIT, FAULT.
- HI: if FetchPC+1 >= MEM_BYTES -> Fault=1, FaultPC=FetchPC, no request, go FAULT. Else if count < FIFO_DEPTH: request FetchPC, go LO. Else MemRdEn=0, go WAIT.
- LO: request FetchPC+1, capture high byte, go CAP.
- CAP: capture low byte, push {FetchPC,{hi,lo}}, FetchPC <= FetchPC+2 (mod 2^16). In the same cycle, apply the HI decision for the new PC (range check against FetchPC+2). Space counts this push plus any same-cycle pop. Issue -> LO, full -> WAIT, out of range -> FAULT.
- WAIT: no request; when count < FIFO_DEPTH, apply the HI decision.
- FAULT: no requests. FIFO keeps draining. Fault and FaultPC hold until BranchTaken or Reset.
- Steady-state throughput: 1 instruction per 2 cycles. Reset release -> first InstrValid=1 in cycle 4 (request cycles 1,2; capture 3; valid 4).
- Handshake: pop on InstrValid&&InstrReady. Instruction/InstrPC stable while InstrValid&&!InstrReady. Push and pop in the same cycle are both honoured. Push never occurs when full.
- BranchTaken (priority below Reset): the same-cycle pop, if any, completes. Then the FIFO is flushed, in-flight bytes are dropped, Fault clears, FetchPC=BranchTarget, and the state goes to HI. InstrValid=0 next cycle. First redirected instruction is valid 3 cycles after the HI cycle.
- Back-to-back BranchTaken: the last target wins.

Optional Feature:
ALIGN_CHECK_EN: when defined, BranchTaken with BranchTarget[0]=1 flushes as normal, then sets Fault=1, FaultPC=BranchTarget, and goes to FAULT with no request. RESET_PC must be even. When undefined, odd targets are fetched normally (hi=mem[T], lo=mem[T+1]).

Test Plan:
- Mem bytes 0..5 = 12,34,56,78,9A,BC (hex), InstrReady=1, release Reset -> valid cycle 4: Instruction=1234 PC=0, then 5678 PC=2, 9ABC PC=4 at 2-cycle spacing.
- InstrReady=0 for 10 cycles -> FIFO fills to FIFO_DEPTH, MemRdEn stays 0, head holds 1234. Raise InstrReady -> 1234, 5678, 9ABC in order, no loss or duplication.
- BranchTaken with target 0x0040 while the LO request is in flight -> stale byte dropped, next InstrValid shows InstrPC=0x0040 with {mem[40],mem[41]}.
- MEM_BYTES=128, branch to 0x007E -> one instruction at 0x007E, then Fault=1 with FaultPC=0x0080 and no further MemRdEn. Branch to 0 clears Fault.
- Branch to 0x007F -> Fault=1, FaultPC=0x007F with no request issued. With ALIGN_CHECK_EN, branch to 0x0003 -> Fault=1, FaultPC=0x0003; without it, {mem[3],mem[4]}=789A.
- Assert Reset mid-fetch with 2 entries buffered -> next cycle InstrValid=0, Fault=0, and fetch restarts at RESET_PC.
